// File: rtl/audio_sample_buffer.sv
// Audio sample FIFO between the packet decoder and the DAC: 16 x 32-bit buffer,
// IDLE/PLAY/DRAIN playback control, optional 22 kHz sample repetition.
module audio_sample_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        audio_starts,
  input  logic        audio_22khz,
  input  logic        is_audio_sample,
  input  logic        end_audio_sample,
  input  logic        all_1_packet,
  input  logic        sample_req,
  output logic [31:0] sample_out,
  output logic        sample_valid,
  output logic        playing,
  output logic        data_req,
  output logic [4:0]  fifo_level,
  output logic        underrun,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_q [16];
  logic [31:0] rd_data_q;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [4:0]  level_q, level_d;
  logic        repeat_q, repeat_d;
  logic        mode_22k_q, mode_22k_d;
  logic        out_en_q, out_en_d;
  logic        valid_q;
  logic        underrun_q, underrun_d;
  logic        overflow_q, overflow_d;

  logic flush, start, has_data, serve, pop, push_req, push;

  always_comb begin
    flush    = in_valid & all_1_packet;
    start    = in_valid & audio_starts;
    has_data = (state_q != IDLE) && (level_q != 5'd0);
    serve    = sample_req & has_data & ~flush;
    // In 22 kHz mode every entry is handed out twice; only the second hand-out pops.
    pop      = serve & (~mode_22k_q | repeat_q);
    push_req = in_valid & is_audio_sample & (state_q == PLAY) & ~flush;
    push     = push_req & ((level_q != 5'd16) | pop);

    overflow_d = push_req & (level_q == 5'd16) & ~pop;
    underrun_d = sample_req & (state_q == PLAY) & (level_q == 5'd0) & ~flush;
    out_en_d   = serve;

    rd_ptr_d   = rd_ptr_q + {3'd0, pop};
    wr_ptr_d   = wr_ptr_q + {3'd0, push};
    level_d    = level_q + {4'd0, push} - {4'd0, pop};
    repeat_d   = serve ? (mode_22k_q & ~repeat_q) : repeat_q;
    mode_22k_d = mode_22k_q;
    state_d    = state_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = PLAY;
          mode_22k_d = audio_22khz;
        end
      end
      PLAY: begin
        if (in_valid & end_audio_sample) state_d = DRAIN;
      end
      DRAIN: begin
        if (start) begin
          state_d    = PLAY;
          mode_22k_d = audio_22khz;
        end else if ((level_q == 5'd0) && !repeat_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides every other event decided above.
    if (flush) begin
      state_d    = IDLE;
      rd_ptr_d   = 4'd0;
      wr_ptr_d   = 4'd0;
      level_d    = 5'd0;
      repeat_d   = 1'b0;
      mode_22k_d = mode_22k_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
    if (sample_req) rd_data_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= 4'd0;
      wr_ptr_q   <= 4'd0;
      level_q    <= 5'd0;
      repeat_q   <= 1'b0;
      mode_22k_q <= 1'b0;
      out_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      repeat_q   <= repeat_d;
      mode_22k_q <= mode_22k_d;
      out_en_q   <= out_en_d;
      valid_q    <= sample_req;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Starved or idle requests still get a valid pulse, but with zero data.
  assign sample_out   = out_en_q ? rd_data_q : 32'd0;
  assign sample_valid = valid_q;
  assign playing      = (state_q != IDLE);
  assign data_req     = (state_q == PLAY) && (level_q <= 5'd8);
  assign fifo_level   = level_q;
  assign underrun     = underrun_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Bench for audio_sample_buffer: directed vector table, multi-cycle corner sequences,
// and a randomized run checked against a queue-based playback model.
module tb_audio_sample_buffer;

  logic        clk = 1'b0;
  logic        reset, in_valid, audio_starts, audio_22khz, is_audio_sample;
  logic        end_audio_sample, all_1_packet, sample_req;
  logic [31:0] in_data, sample_out;
  logic        sample_valid, playing, data_req, underrun, overflow;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  audio_sample_buffer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .audio_starts(audio_starts), .audio_22khz(audio_22khz),
    .is_audio_sample(is_audio_sample), .end_audio_sample(end_audio_sample),
    .all_1_packet(all_1_packet), .sample_req(sample_req),
    .sample_out(sample_out), .sample_valid(sample_valid), .playing(playing),
    .data_req(data_req), .fifo_level(fifo_level), .underrun(underrun),
    .overflow(overflow)
  );

  localparam bit [7:0] NOP = 8'h00, RST = 8'h80, V = 8'h40, ST = 8'h20, K22 = 8'h10;
  localparam bit [7:0] SMP = 8'h08, EN = 8'h04, A1 = 8'h02, REQ = 8'h01;
  localparam int M_IDLE = 0, M_PLAY = 1, M_DRAIN = 2;

  int n_vec = 0;
  int n_bad = 0;

  // Playback model: queue of buffered samples plus the playback mode.
  int          m_state = M_IDLE;
  bit          m_k22 = 1'b0, m_rep = 1'b0;
  logic [31:0] m_q[$];
  bit          e_sv, e_ur, e_ov;
  logic [31:0] e_out;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, bit exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic model_step();
    int pre_size   = m_q.size();
    bit pre_rep    = m_rep;
    bit popped     = 1'b0;
    bit do_push    = 1'b0;
    e_sv = sample_req; e_out = 32'd0; e_ur = 1'b0; e_ov = 1'b0;
    if (reset) begin
      m_q.delete(); m_state = M_IDLE; m_rep = 1'b0; m_k22 = 1'b0; e_sv = 1'b0;
      return;
    end
    if (in_valid && all_1_packet) begin
      m_q.delete(); m_rep = 1'b0; m_state = M_IDLE;
      return;
    end
    if (sample_req) begin
      if (m_state != M_IDLE && pre_size > 0) begin
        e_out = m_q[0];
        if (m_k22 && !m_rep) m_rep = 1'b1;
        else begin popped = 1'b1; m_rep = 1'b0; end
      end else if (m_state == M_PLAY) begin
        e_ur = 1'b1;
      end
    end
    if (in_valid && is_audio_sample && m_state == M_PLAY) begin
      if (pre_size < 16 || popped) do_push = 1'b1;
      else e_ov = 1'b1;
    end
    if (popped) void'(m_q.pop_front());
    if (do_push) m_q.push_back(in_data);
    if (m_state == M_IDLE && in_valid && audio_starts) begin
      m_state = M_PLAY; m_k22 = audio_22khz;
    end else if (m_state == M_PLAY && in_valid && end_audio_sample) begin
      m_state = M_DRAIN;
    end else if (m_state == M_DRAIN) begin
      if (in_valid && audio_starts) begin m_state = M_PLAY; m_k22 = audio_22khz; end
      else if (pre_size == 0 && !pre_rep) m_state = M_IDLE;
    end
  endtask

  task automatic apply(bit [7:0] f, logic [31:0] d);
    {reset, in_valid, audio_starts, audio_22khz} = f[7:4];
    {is_audio_sample, end_audio_sample, all_1_packet, sample_req} = f[3:0];
    in_data = d;
    model_step();
    @(posedge clk); #1;
    chk1("model sample_valid", sample_valid, e_sv);
    chk("model sample_out", sample_out, e_out);
    chk1("model underrun", underrun, e_ur);
    chk1("model overflow", overflow, e_ov);
    chk("model fifo_level", {27'd0, fifo_level}, m_q.size());
    chk1("model playing", playing, m_state != M_IDLE);
    chk1("model data_req", data_req, (m_state == M_PLAY) && (m_q.size() <= 8));
  endtask

  typedef struct {
    bit [7:0]    f;
    logic [31:0] d;
    bit          sv;
    logic [31:0] out;
    int          lvl;
    bit          ply, dr, ur, ov;
  } vec_t;

  function automatic vec_t mk(bit [7:0] f, logic [31:0] d, bit sv, logic [31:0] o,
                              int lvl, bit ply, bit dr, bit ur, bit ov);
    vec_t v;
    v.f = f; v.d = d; v.sv = sv; v.out = o; v.lvl = lvl;
    v.ply = ply; v.dr = dr; v.ur = ur; v.ov = ov;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bit [7:0] f;
    bit       prev_req;

    {reset, in_valid, audio_starts, audio_22khz} = 4'b1000;
    {is_audio_sample, end_audio_sample, all_1_packet, sample_req} = 4'b0000;
    in_data = 32'd0;

    // Reset state.
    apply(RST, 32'd0);
    chk("reset sample_out", sample_out, 32'd0);
    chk1("reset sample_valid", sample_valid, 1'b0);
    chk1("reset playing", playing, 1'b0);
    chk1("reset data_req", data_req, 1'b0);
    chk("reset fifo_level", {27'd0, fifo_level}, 32'd0);

    // 44 kHz basic, 22 kHz repeat + underrun, write-with-start, idle behaviour.
    tbl.push_back(mk(V|ST,      32'h0,        0, 32'h0,        0, 1, 1, 0, 0));
    tbl.push_back(mk(V|SMP,     32'h00010002, 0, 32'h0,        1, 1, 1, 0, 0));
    tbl.push_back(mk(V|SMP,     32'h00030004, 0, 32'h0,        2, 1, 1, 0, 0));
    tbl.push_back(mk(REQ,       32'h0,        1, 32'h00010002, 1, 1, 1, 0, 0));
    tbl.push_back(mk(NOP,       32'h0,        0, 32'h0,        1, 1, 1, 0, 0));
    tbl.push_back(mk(REQ,       32'h0,        1, 32'h00030004, 0, 1, 1, 0, 0));
    tbl.push_back(mk(NOP,       32'h0,        0, 32'h0,        0, 1, 1, 0, 0));
    tbl.push_back(mk(V|A1,      32'h0,        0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk(V|ST|K22,  32'h0,        0, 32'h0,        0, 1, 1, 0, 0));
    tbl.push_back(mk(V|SMP,     32'hAAAA5555, 0, 32'h0,        1, 1, 1, 0, 0));
    tbl.push_back(mk(REQ,       32'h0,        1, 32'hAAAA5555, 1, 1, 1, 0, 0));
    tbl.push_back(mk(NOP,       32'h0,        0, 32'h0,        1, 1, 1, 0, 0));
    tbl.push_back(mk(REQ,       32'h0,        1, 32'hAAAA5555, 0, 1, 1, 0, 0));
    tbl.push_back(mk(NOP,       32'h0,        0, 32'h0,        0, 1, 1, 0, 0));
    tbl.push_back(mk(REQ,       32'h0,        1, 32'h0,        0, 1, 1, 1, 0));
    tbl.push_back(mk(NOP,       32'h0,        0, 32'h0,        0, 1, 1, 0, 0));
    tbl.push_back(mk(REQ,       32'h0,        1, 32'h0,        0, 1, 1, 1, 0));
    tbl.push_back(mk(V|A1,      32'h0,        0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk(V|ST|SMP,  32'h12345678, 0, 32'h0,        0, 1, 1, 0, 0));
    tbl.push_back(mk(NOP,       32'h0,        0, 32'h0,        0, 1, 1, 0, 0));
    tbl.push_back(mk(V|A1,      32'h0,        0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk(REQ,       32'h0,        1, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk(V|SMP,     32'hDEADBEEF, 0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk(V|ST,      32'h0,        0, 32'h0,        0, 1, 1, 0, 0));
    tbl.push_back(mk(REQ,       32'h0,        1, 32'h0,        0, 1, 1, 1, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].f, tbl[i].d);
      chk1($sformatf("row%0d sample_valid", i), sample_valid, tbl[i].sv);
      chk($sformatf("row%0d sample_out", i), sample_out, tbl[i].out);
      chk($sformatf("row%0d fifo_level", i), {27'd0, fifo_level}, tbl[i].lvl);
      chk1($sformatf("row%0d playing", i), playing, tbl[i].ply);
      chk1($sformatf("row%0d data_req", i), data_req, tbl[i].dr);
      chk1($sformatf("row%0d underrun", i), underrun, tbl[i].ur);
      chk1($sformatf("row%0d overflow", i), overflow, tbl[i].ov);
    end

    // Fill to 16, overflow on the 17th, push+pop at full.
    apply(RST, 32'd0);
    apply(V|ST, 32'd0);
    for (int i = 0; i < 16; i++) apply(V|SMP, 32'h100 + i);
    chk("full level", {27'd0, fifo_level}, 32'd16);
    chk1("full no overflow", overflow, 1'b0);
    chk1("full data_req", data_req, 1'b0);
    apply(V|SMP, 32'h1FF);
    chk1("17th overflow", overflow, 1'b1);
    chk("17th level", {27'd0, fifo_level}, 32'd16);
    apply(V|SMP|REQ, 32'h200);
    chk1("push+pop overflow", overflow, 1'b0);
    chk("push+pop level", {27'd0, fifo_level}, 32'd16);
    chk("push+pop out", sample_out, 32'h100);
    apply(NOP, 32'd0);
    chk1("overflow one-shot", overflow, 1'b0);

    // Drain three entries after end_audio_sample.
    apply(RST, 32'd0);
    apply(V|ST, 32'd0);
    for (int i = 0; i < 3; i++) apply(V|SMP, 32'h11 * (i + 1));
    apply(V|EN, 32'd0);
    chk1("drain playing", playing, 1'b1);
    chk1("drain data_req", data_req, 1'b0);
    chk("drain level", {27'd0, fifo_level}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      apply(REQ, 32'd0);
      chk($sformatf("drain out%0d", i), sample_out, 32'h11 * (i + 1));
      chk1($sformatf("drain underrun%0d", i), underrun, 1'b0);
      chk1($sformatf("drain playing%0d", i), playing, 1'b1);
      apply(NOP, 32'd0);
    end
    chk1("drain done playing", playing, 1'b0);
    chk("drain done level", {27'd0, fifo_level}, 32'd0);

    // Flush and mid-stream reset both leave an empty idle buffer.
    for (int k = 0; k < 2; k++) begin
      apply(RST, 32'd0);
      apply(V|ST, 32'd0);
      for (int i = 0; i < 5; i++) apply(V|SMP, 32'h5000 + i);
      chk($sformatf("abort%0d pre level", k), {27'd0, fifo_level}, 32'd5);
      apply((k == 0) ? (V|A1) : RST, 32'd0);
      chk($sformatf("abort%0d level", k), {27'd0, fifo_level}, 32'd0);
      chk1($sformatf("abort%0d playing", k), playing, 1'b0);
      apply(REQ, 32'd0);
      chk1($sformatf("abort%0d valid", k), sample_valid, 1'b1);
      chk($sformatf("abort%0d out", k), sample_out, 32'd0);
      chk1($sformatf("abort%0d underrun", k), underrun, 1'b0);
    end

    // Randomized traffic against the model.
    prev_req = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      int r = $urandom_range(0, 199);
      f = NOP;
      if (r < 80)       f = V|SMP;
      else if (r < 86)  f = V|ST | (($urandom_range(0, 1) == 1) ? K22 : NOP);
      else if (r < 90)  f = V|EN;
      else if (r < 92)  f = V|A1;
      else if (r < 100) f = SMP | ST | EN;
      else if (r == 100) f = RST;
      if ($urandom_range(0, 3) == 0) f = f | K22;
      if (!prev_req && $urandom_range(0, 2) != 0) f = f | REQ;
      prev_req = f[0];
      apply(f, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_sample_buffer.md
AUDIO_SAMPLE_BUFFER -- requirements
Module: audio_sample_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  qualifies decoder flags and in_data for one cycle; flags ignored when low.
REQ-005 in_data  in  32  packet payload: [31:16] left sample, [15:0] right sample.
REQ-006 audio_starts, audio_22khz, is_audio_sample, end_audio_sample, all_1_packet  in  1 each  op-decoder flags, one-hot except audio_22khz.
REQ-007 sample_req  in  1  DAC frame request, single-cycle pulse, at most one per 2 cycles.
REQ-008 sample_out  out  32  sample delivered to DAC.
REQ-009 sample_valid  out  1  one-cycle pulse qualifying sample_out.
REQ-010 playing  out  1  high in PLAY or DRAIN.
REQ-011 data_req  out  1  high in PLAY when fifo_level <= 8.
REQ-012 fifo_level  out  5  occupied entries, 0..16.
REQ-013 underrun  out  1  one-cycle pulse on starved request in PLAY.
REQ-014 overflow  out  1  one-cycle pulse on dropped sample.

Function
REQ-015 The block SHALL hold a 16-entry x 32-bit FIFO with wrap-around 4-bit read/write pointers and a 5-bit level.
REQ-016 The state machine SHALL have states IDLE, PLAY, DRAIN.
REQ-017 IDLE->PLAY on in_valid&audio_starts, latching mode_22k=audio_22khz; FIFO contents kept.
REQ-018 DRAIN->PLAY on in_valid&audio_starts, relatching mode_22k.
REQ-019 PLAY->DRAIN on in_valid&end_audio_sample.
REQ-020 DRAIN->IDLE on the cycle where level==0 and no repeat is pending.
REQ-021 in_valid&all_1_packet in any state SHALL flush (pointers, level, repeat flag to 0) and go IDLE next cycle, taking priority over every other event that cycle.
REQ-022 A sample (in_valid&is_audio_sample) SHALL be written only in PLAY; in IDLE or DRAIN it is silently ignored, with no overflow.
REQ-023 In PLAY, a sample when level==16 and no pop that cycle SHALL be dropped and pulse overflow.
REQ-024 Simultaneous push and pop SHALL both occur, level unchanged, including at level 16 (no overflow).
REQ-025 sample_req in cycle N SHALL produce sample_valid=1 with sample_out in cycle N+1 (1-cycle latency), in every state.
REQ-026 In PLAY/DRAIN with level>0, sample_out SHALL be the head entry.
REQ-027 In 44 kHz mode, every request pops.
REQ-028 In 22 kHz mode, the first request on an entry outputs it without popping and sets repeat; the second outputs the same entry, pops, and clears repeat.
REQ-029 In PLAY with level==0, sample_out=0 and underrun SHALL pulse in N+1.
REQ-030 In IDLE, or in DRAIN with level==0, sample_out=0 and no underrun.
REQ-031 fifo_level and data_req SHALL reflect the registered state (valid the cycle after a push/pop).
REQ-032 A sample written in the same cycle as audio_starts from IDLE SHALL be ignored (state not yet PLAY).

Reset
REQ-033 On reset: state IDLE, pointers/level/repeat/mode_22k 0, sample_out 0, sample_valid/underrun/overflow/playing/data_req 0, fifo_level 0.
REQ-034 Reset mid-stream SHALL discard all buffered samples; the first post-reset request returns 0 with no underrun.

Verification
REQ-035 audio_starts (44k), write 0x00010002, 0x00030004, then 2 requests -> sample_valid one cycle after each, outputs 0x00010002, 0x00030004; level 2->0.
REQ-036 audio_starts with 22khz=1, write 0xAAAA5555, 4 requests -> outputs 0xAAAA5555, 0xAAAA5555, 0, 0; underrun on 3rd and 4th only.
REQ-037 PLAY, write 17 samples with no requests -> level 16, overflow pulse on 17th; simultaneous push+pop at 16 -> level 16, no overflow.
REQ-038 PLAY, level 3, end_audio_sample -> DRAIN, playing=1, data_req=0; 3 requests drain, IDLE next cycle, playing=0, no underrun.
REQ-039 PLAY, level 5, all_1_packet -> IDLE, level 0 next cycle; following request outputs 0, no underrun; reset asserted mid-PLAY gives identical result.
